// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the rv32i pipeline controller.
// Used by pipeline_ctrl and the optional pipe_perf_cnt counter block.
package pipeline_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DRAIN = 2'd1,
    PC_TRAP  = 2'd2
  } pc_state_t;

  localparam logic [DATA_WIDTH-1:0] MCAUSE_ECALL    = 32'd11;
  localparam logic [DATA_WIDTH-1:0] MCAUSE_EBREAK   = 32'd3;
  localparam logic [DATA_WIDTH-1:0] TRAP_VECTOR_DEF = 32'h0000_0100;

  localparam logic STALL_EN  = 1'b1;
  localparam logic STALL_DIS = 1'b0;
  localparam logic ENV_EXC   = 1'b1;
  localparam logic BP_EXC    = 1'b0;

  // Per-cycle pipeline control bundle driven by the output decode
  typedef struct packed {
    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  pc_redirect;
    logic [DATA_WIDTH-1:0] redirect_addr;
    logic                  exc_clear;
    logic                  exc_active;
  } pipe_ctrl_t;

  // ECALL outranks EBREAK when both are decoded together
  function automatic logic [DATA_WIDTH-1:0] cause_of(input logic kind);
    return (kind == ENV_EXC) ? MCAUSE_ECALL : MCAUSE_EBREAK;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrap-around stall and IF/ID flush cycle counters.
// Instantiated by pipeline_ctrl only when PIPE_PERF_CNT_EN is defined.
module pipe_perf_cnt
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] stall_cycles,
  output logic [DATA_WIDTH-1:0] flush_cycles
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + DATA_WIDTH'(1);
      if (flush) flush_cycles <= flush_cycles + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect control and exception-entry sequencer.
// Optional perf counters (stall_cycles/flush_cycles) under PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned           DRAIN_CYCLES = 3,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hz_stall,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  env_exception,
  input  logic                  bp_exception,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  pc_redirect,
  output logic [DATA_WIDTH-1:0] redirect_addr,
  output logic                  exc_clear,
  output logic                  exc_active,
  output logic [DATA_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] mcause
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] stall_cycles,
  output logic [DATA_WIDTH-1:0] flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  pc_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
  logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
  pipe_ctrl_t            ctl;
  logic                  exc_req;

  assign exc_req = env_exception | bp_exception;

  // State register plus exception capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PC_RUN;
      cnt_q    <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    case (state_q)
      PC_RUN: begin
        if (exc_req) begin
          mepc_d   = id_pc;
          mcause_d = cause_of(env_exception ? ENV_EXC : BP_EXC);
          cnt_d    = DRAIN_LOAD;
          state_d  = PC_DRAIN;
        end
      end
      PC_DRAIN: begin
        if (cnt_q == '0) state_d = PC_TRAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      PC_TRAP: state_d = PC_RUN;
      default: state_d = PC_RUN;
    endcase
  end

  // Output decode; stall wins over branch so a held branch is re-evaluated later
  always_comb begin
    ctl = '0;
    case (state_q)
      PC_RUN: begin
        if (exc_req) begin
          ctl.idex_flush = 1'b1;
          ctl.exc_active = 1'b1;
        end else if (hz_stall == STALL_EN) begin
          ctl.idex_flush = 1'b1;
        end else if (br_taken) begin
          ctl.pc_write_en   = 1'b1;
          ctl.pc_redirect   = 1'b1;
          ctl.redirect_addr = br_target;
          ctl.ifid_flush    = 1'b1;
        end else begin
          ctl.pc_write_en   = 1'b1;
          ctl.ifid_write_en = 1'b1;
        end
      end
      PC_DRAIN: begin
        ctl.idex_flush = 1'b1;
        ctl.exc_active = 1'b1;
      end
      PC_TRAP: begin
        ctl.pc_write_en   = 1'b1;
        ctl.pc_redirect   = 1'b1;
        ctl.redirect_addr = TRAP_VECTOR;
        ctl.ifid_flush    = 1'b1;
        ctl.idex_flush    = 1'b1;
        ctl.exc_clear     = 1'b1;
        ctl.exc_active    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  assign pc_write_en   = ctl.pc_write_en;
  assign ifid_write_en = ctl.ifid_write_en;
  assign ifid_flush    = ctl.ifid_flush;
  assign idex_flush    = ctl.idex_flush;
  assign pc_redirect   = ctl.pc_redirect;
  assign redirect_addr = ctl.redirect_addr;
  assign exc_clear     = ctl.exc_clear;
  assign exc_active    = ctl.exc_active;
  assign mepc          = mepc_q;
  assign mcause        = mcause_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (~ctl.pc_write_en),
    .flush        (ctl.ifid_flush),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expectations are queued as stimulus is driven
// and compared on the following negedge. Perf counter checks need PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hz_stall, br_taken, env_exception, bp_exception;
  logic [31:0] br_target, id_pc;
  logic        pc_write_en, ifid_write_en, ifid_flush, idex_flush;
  logic        pc_redirect, exc_clear, exc_active;
  logic [31:0] redirect_addr, mepc, mcause;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // ctl bit order: pc_we, ifid_we, ifid_flush, idex_flush, redirect, exc_clear, exc_active
  localparam logic [6:0] C_IDLE  = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1010100;
  localparam logic [6:0] C_EXC   = 7'b0001001;
  localparam logic [6:0] C_TRAP  = 7'b1011111;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [31:0] raddr;
    logic [31:0] mepc;
    logic [31:0] mcause;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .TRAP_VECTOR(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hz_stall      (hz_stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .id_pc         (id_pc),
    .env_exception (env_exception),
    .bp_exception  (bp_exception),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .pc_redirect   (pc_redirect),
    .redirect_addr (redirect_addr),
    .exc_clear     (exc_clear),
    .exc_active    (exc_active),
    .mepc          (mepc),
    .mcause        (mcause)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare on the negedge
  task automatic step(input string tag, input logic rst, input logic stall, input logic brt,
                      input logic [31:0] tgt, input logic [31:0] pc, input logic env,
                      input logic bp, input logic [6:0] ctl, input logic [31:0] raddr,
                      input logic [31:0] e_mepc, input logic [31:0] e_mcause);
    exp_t e;
    exp_t o;
    rst_n = rst; hz_stall = stall; br_taken = brt; br_target = tgt;
    id_pc = pc; env_exception = env; bp_exception = bp;
    e.tag = tag; e.ctl = ctl; e.raddr = raddr; e.mepc = e_mepc; e.mcause = e_mcause;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    check({o.tag, ".ctl"}, 32'({pc_write_en, ifid_write_en, ifid_flush, idex_flush,
                                pc_redirect, exc_clear, exc_active}), 32'(o.ctl));
    check({o.tag, ".raddr"}, redirect_addr, o.raddr);
    check({o.tag, ".mepc"}, mepc, o.mepc);
    check({o.tag, ".mcause"}, mcause, o.mcause);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hz_stall = 1'b0; br_taken = 1'b0; br_target = '0;
    id_pc = '0; env_exception = 1'b0; bp_exception = 1'b0;
    @(posedge clk);
    #1;
    // Reset held two cycles
    step("rst0", 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
    step("idle", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
    // Stall masks a pending branch, which then redirects once the stall drops
    step("stall0", 1, 1, 1, 32'h40, 0, 0, 0, C_STALL, 0, 0, 0);
    step("stall1", 1, 1, 1, 32'h40, 0, 0, 0, C_STALL, 0, 0, 0);
    step("branch", 1, 0, 1, 32'h40, 0, 0, 0, C_BR, 32'h40, 0, 0);
    step("idle2", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
    // ECALL: accept, 3 drain cycles ignoring other inputs, trap, back to run
    step("ecall.acc", 1, 0, 0, 0, 32'h1C, 1, 0, C_EXC, 0, 0, 0);
    step("ecall.dr0", 1, 1, 1, 32'h80, 32'h50, 1, 0, C_EXC, 0, 32'h1C, 11);
    step("ecall.dr1", 1, 0, 1, 32'h80, 32'h50, 1, 1, C_EXC, 0, 32'h1C, 11);
    step("ecall.dr2", 1, 0, 0, 0, 0, 1, 0, C_EXC, 0, 32'h1C, 11);
    step("ecall.trap", 1, 0, 1, 32'h80, 0, 1, 0, C_TRAP, 32'h100, 32'h1C, 11);
    step("ecall.run", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 32'h1C, 11);
    // Both flags: ECALL cause wins
    step("both.acc", 1, 1, 0, 0, 32'h20, 1, 1, C_EXC, 0, 32'h1C, 11);
    step("both.dr0", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h20, 11);
    step("both.dr1", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h20, 11);
    step("both.dr2", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h20, 11);
    step("both.trap", 1, 0, 0, 0, 0, 0, 0, C_TRAP, 32'h100, 32'h20, 11);
    // EBREAK alone
    step("ebrk.acc", 1, 0, 1, 32'h44, 32'h24, 0, 1, C_EXC, 0, 32'h20, 11);
    step("ebrk.dr0", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h24, 3);
    step("ebrk.dr1", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h24, 3);
    step("ebrk.dr2", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h24, 3);
    step("ebrk.trap", 1, 0, 0, 0, 0, 0, 0, C_TRAP, 32'h100, 32'h24, 3);
    step("ebrk.run", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 32'h24, 3);
    // Reset in the second drain cycle aborts the sequence without exc_clear
    step("abort.acc", 1, 0, 0, 0, 32'h30, 1, 0, C_EXC, 0, 32'h24, 3);
    step("abort.dr0", 1, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h30, 11);
    step("abort.dr1", 0, 0, 0, 0, 0, 0, 0, C_EXC, 0, 32'h30, 11);
    step("abort.run", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
    step("abort.run2", 1, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
    // Counters restart from reset above: 5 stalls then one branch flush
    for (int i = 0; i < 5; i++)
      step("perf.stall", 1, 1, 0, 0, 0, 0, 0, C_STALL, 0, 0, 0);
    step("perf.br", 1, 0, 1, 32'h60, 0, 0, 0, C_BR, 32'h60, 0, 0);
    check("perf.stall_cycles", stall_cycles, 32'd5);
    check("perf.flush_cycles", flush_cycles, 32'd1);
    force dut.u_perf.stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.stall_cycles;
    step("perf.wrap", 1, 1, 0, 0, 0, 0, 0, C_STALL, 0, 0, 0);
    check("perf.wrap", stall_cycles, 32'd0);
`endif
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard residue got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer of the ID-stage stall request and of the decode exception flags.
- Converts them into per-stage write-enable, bubble, flush and PC-redirect controls for the 5-stage rv32i pipeline.
- Owns the exception-entry sequence: drain EX/MEM/WB, capture mepc/mcause, redirect fetch to the trap vector, then clear the exception back to decode.

Parameters:
- DRAIN_CYCLES, 3, cycles held in DRAIN so older instructions retire; legal range 1..7.
- TRAP_VECTOR, 32'h0000_0100, fetch address driven on trap entry.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- hz_stall  input  1  stall request from hazard detection; 1 = stall
- br_taken  input  1  ID-stage branch/jump resolved taken
- br_target  input  32  ID-stage branch/jump target
- id_pc  input  32  PC of the instruction in ID
- env_exception  input  1  ECALL decoded in ID
- bp_exception  input  1  EBREAK decoded in ID
- pc_write_en  output  1  PC register update enable
- ifid_write_en  output  1  IF/ID register update enable
- ifid_flush  output  1  IF/ID register loads a NOP
- idex_flush  output  1  ID/EX register loads a bubble
- pc_redirect  output  1  PC mux selects redirect_addr
- redirect_addr  output  32  redirect target
- exc_clear  output  1  one-cycle pulse telling decode to drop the exception flags
- exc_active  output  1  high from exception accept until exc_clear
- mepc  output  32  registered PC of the excepting instruction
- mcause  output  32  registered cause: 11 for ECALL, 3 for EBREAK

Behaviour:
- Single clk domain. rst_n is synchronous and active-low.
- On reset: state=RUN, mepc=0, mcause=0, drain counter=0.
- All outputs are combinational from state and inputs. With reset held in RUN and all inputs 0: pc_write_en=1, ifid_write_en=1, all other outputs 0.
- FSM states: RUN, DRAIN, TRAP.
- RUN, priority order (highest first):
  - (a) env_exception or bp_exception:
    - Capture mepc<=id_pc.
    - Capture mcause<=11 if env_exception, else 3. env_exception wins if both are set.
    - Load cnt<=DRAIN_CYCLES-1 and go to DRAIN.
    - This cycle: pc_write_en=0, ifid_write_en=0, idex_flush=1, exc_active=1.
  - (b) hz_stall: pc_write_en=0, ifid_write_en=0, idex_flush=1. Any br_taken is ignored; it is re-evaluated after the stall clears.
  - (c) br_taken: pc_redirect=1, redirect_addr=br_target, ifid_flush=1, pc_write_en=1.
  - (d) otherwise: pc_write_en=1, ifid_write_en=1.
- DRAIN:
  - pc_write_en=0, ifid_write_en=0, idex_flush=1, exc_active=1.
  - cnt decrements each cycle; when cnt==0, go to TRAP.
  - hz_stall, br_taken and the exception inputs are ignored.
- TRAP (exactly 1 cycle):
  - pc_redirect=1, redirect_addr=TRAP_VECTOR, pc_write_en=1.
  - ifid_flush=1, idex_flush=1, exc_clear=1, exc_active=1.
  - Next state is RUN.
- Latency, exception accept to trap redirect: DRAIN_CYCLES+1 cycles. The first trap-vector fetch happens in the cycle after TRAP.
- mepc and mcause hold their values until the next exception accept.
- Reset asserted mid-DRAIN or mid-TRAP: the next cycle is RUN with cleared registers and no exc_clear pulse.
- Exception flags still high in the first RUN cycle after TRAP are treated as a new exception. Decode must honour exc_clear.
- Flush has priority over write-enable: if ifid_flush=1, IF/ID loads a NOP regardless of ifid_write_en.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_cycles[31:0], both 0 on reset.
  - stall_cycles increments on every cycle with pc_write_en=0.
  - flush_cycles increments on every cycle with ifid_flush=1.
  - Both wrap from 32'hFFFF_FFFF to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- The shared define header carries:
  - FSM state encodings: PC_RUN, PC_DRAIN, PC_TRAP.
  - MCAUSE_ECALL=11 and MCAUSE_EBREAK=3.
  - TRAP_VECTOR default.
  - STALL_EN/STALL_DIS, ENV_EXC/BP_EXC, DATA_WIDTH.
- One natural sub-module, pipe_perf_cnt, holding the two wrap-around counters; instantiated only under PIPE_PERF_CNT_EN.
- The FSM and the output decode stay flat in pipeline_ctrl.

Test Plan:
- Reset held 2 cycles, inputs 0 -> pc_write_en=1, ifid_write_en=1, other outputs 0, mepc=0, mcause=0.
- hz_stall=1 for 2 cycles with br_taken=1, br_target=0x40 -> pc_write_en=0, idex_flush=1, pc_redirect=0 both cycles. Then hz_stall=0 with br_taken=1 -> pc_redirect=1, redirect_addr=0x40, ifid_flush=1.
- env_exception=1 with id_pc=0x1C, DRAIN_CYCLES=3 -> mepc=0x1C, mcause=11, 3 DRAIN cycles, then TRAP with redirect_addr=0x100 and a single exc_clear pulse 4 cycles after accept.
- env_exception=1 and bp_exception=1 together -> mcause=11. bp_exception alone -> mcause=3.
- rst_n=0 asserted in the second DRAIN cycle -> next cycle is RUN, exc_active=0, no exc_clear pulse, mepc=0.
- PIPE_PERF_CNT_EN defined: 5 stall cycles plus 1 branch flush -> stall_cycles=5, flush_cycles=1. Preload stall_cycles=0xFFFF_FFFF and stall once -> stall_cycles=0.
